// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: DEPTH-entry instruction prefetch FIFO between the bus
// fetch port and decode. Fetch keeps running while decode stalls; a redirect
// (branch, trap, mret) flushes every queued entry and restarts fetch at a new
// word-aligned vector.
module fetch_prefetch_queue #(
   parameter int               DEPTH        = 4,
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        redirect,
   input  logic [XLEN-1:0]             redirect_vector,
   output logic                        fetch_request,
   output logic [XLEN-1:0]             fetch_address,
   input  logic                        fetch_ready,
   input  logic [XLEN-1:0]             fetch_data,
   input  logic                        stall,
   output logic [XLEN-1:0]             pc_out,
   output logic [XLEN-1:0]             next_pc_out,
   output logic [XLEN-1:0]             instruction_out,
   output logic                        valid_out,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [XLEN-1:0]  WORD_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);

   // Architectural state
   logic [XLEN-1:0]  r_fetch_pc;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_entry_pc    [DEPTH];
   logic [XLEN-1:0]  r_entry_instr [DEPTH];

   // Per-cycle handshake decisions
   logic             w_valid;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_request;
   logic [XLEN-1:0]  w_redirect_pc;

   assign w_valid       = (r_count != '0);
   assign w_full        = (r_count == FULL_COUNT);
   // A redirect cycle neither consumes the head nor accepts a fetched word.
   assign w_pop         = w_valid & ~stall & ~redirect;
   // A full queue may still request when the head leaves in the same cycle;
   // the stall-to-request path is deliberately combinational.
   assign w_request     = ~reset & ~redirect & (~w_full | w_pop);
   assign w_push        = w_request & fetch_ready;
   assign w_redirect_pc = redirect_vector & ALIGN_MASK;

   assign fetch_request   = w_request;
   assign fetch_address   = r_fetch_pc;
   assign valid_out       = w_valid;
   assign count           = r_count;
   assign pc_out          = r_entry_pc[r_rd_ptr];
   assign next_pc_out     = r_entry_pc[r_rd_ptr] + WORD_STEP;
   assign instruction_out = r_entry_instr[r_rd_ptr];

   // Pointer, occupancy and fetch-address control; redirect overrides push/pop.
   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_VECTOR;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else if (redirect) begin
         r_fetch_pc <= w_redirect_pc;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            r_fetch_pc <= r_fetch_pc + WORD_STEP;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage: capture {pc, instruction} at the write pointer on a push.
   // NOTE: the entry array has no reset; valid_out (from r_count) qualifies
   // every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_entry_pc[r_wr_ptr]    <= r_fetch_pc;
         r_entry_instr[r_wr_ptr] <= fetch_data;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue: directed scenarios, a queue-based
// reference model checked every cycle, and literal expectations per scenario.
module tb_fetch_prefetch_queue;

   localparam int              DEPTH = 4;
   localparam int              XLEN  = 32;
   localparam logic [XLEN-1:0] RV    = 32'h0000_0100;

   logic              clk = 1'b0;
   logic              reset;
   logic              redirect;
   logic [XLEN-1:0]   redirect_vector;
   logic              fetch_request;
   logic [XLEN-1:0]   fetch_address;
   logic              fetch_ready;
   logic [XLEN-1:0]   fetch_data;
   logic              stall;
   logic [XLEN-1:0]   pc_out;
   logic [XLEN-1:0]   next_pc_out;
   logic [XLEN-1:0]   instruction_out;
   logic              valid_out;
   logic [2:0]        count;

   // Model state
   logic [XLEN-1:0]   m_q [$];
   logic [XLEN-1:0]   m_pc;
   int                n_cmp;
   int                n_fail;
   bit                track_pops;
   int                n_pops;
   logic [XLEN-1:0]   last_pop;
   logic [15:0]       stall_pat;

   fetch_prefetch_queue #(
      .DEPTH        (DEPTH),
      .XLEN         (XLEN),
      .RESET_VECTOR (RV)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect        (redirect),
      .redirect_vector (redirect_vector),
      .fetch_request   (fetch_request),
      .fetch_address   (fetch_address),
      .fetch_ready     (fetch_ready),
      .fetch_data      (fetch_data),
      .stall           (stall),
      .pc_out          (pc_out),
      .next_pc_out     (next_pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out),
      .count           (count)
   );

   always #5 clk = ~clk;

   // Memory image: each word is a fixed scramble of its own address.
   function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   assign fetch_data = instr_of(fetch_address);

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: compare at the negedge, then advance to the next edge.
   task automatic model_cycle();
      bit e_valid, e_pop, e_req, e_push;
      if (reset) begin
         m_q.delete();
         m_pc = RV;
         check("rst_fetch_request", {31'b0, fetch_request}, 32'd0);
         check("rst_valid_out",     {31'b0, valid_out},     32'd0);
         check("rst_count",         {29'b0, count},         32'd0);
         return;
      end
      e_valid = (m_q.size() != 0);
      e_pop   = e_valid && !stall && !redirect;
      e_req   = !redirect && ((m_q.size() < DEPTH) || e_pop);
      e_push  = e_req && fetch_ready;
      check("m_fetch_request", {31'b0, fetch_request}, {31'b0, e_req});
      check("m_fetch_address", fetch_address, m_pc);
      check("m_valid_out",     {31'b0, valid_out}, {31'b0, e_valid});
      check("m_count",         {29'b0, count}, 32'(m_q.size()));
      check("m_count_le_depth", {31'b0, (count <= 3'(DEPTH))}, 32'd1);
      if (e_valid) begin
         check("m_pc_out",          pc_out,          m_q[0]);
         check("m_next_pc_out",     next_pc_out,     m_q[0] + 32'd4);
         check("m_instruction_out", instruction_out, instr_of(m_q[0]));
      end
      if (track_pops && e_pop) begin
         check("pop_sequence", pc_out, last_pop + 32'd4);
         last_pop = pc_out;
         n_pops++;
      end
      if (redirect) begin
         m_q.delete();
         m_pc = redirect_vector & ~32'd3;
      end else begin
         if (e_pop) void'(m_q.pop_front());
         if (e_push) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; track_pops = 0; n_pops = 0; last_pop = '0;
      stall_pat = 16'b0110_1001_1100_0101;
      m_pc = RV;
      reset = 1'b1; redirect = 1'b0; redirect_vector = '0;
      fetch_ready = 1'b0; stall = 1'b1;
      #2;
      tick();
      tick();
      reset = 1'b0; fetch_ready = 1'b1; stall = 1'b1;

      // Fill the queue while decode stalls.
      repeat (4) tick();
      check("t1_count",         {29'b0, count}, 32'd4);
      check("t1_fetch_request", {31'b0, fetch_request}, 32'd0);
      check("t1_valid_out",     {31'b0, valid_out}, 32'd1);
      check("t1_pc_out",        pc_out, 32'h100);
      check("t1_next_pc_out",   next_pc_out, 32'h104);
      check("t1_fetch_address", fetch_address, 32'h110);

      // Streaming at full: pop and push together every cycle.
      stall = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         check("t2_pc_out", pc_out, 32'h100 + 32'(4 * k));
         check("t2_count",  {29'b0, count}, 32'd4);
         check("t2_fetch_request", {31'b0, fetch_request}, 32'd1);
         tick();
      end
      stall = 1'b1;

      // Redirect from a full queue.
      redirect = 1'b1; redirect_vector = 32'h0000_2003;
      #1;
      check("t3_req_in_redirect", {31'b0, fetch_request}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      check("t3_count",         {29'b0, count}, 32'd0);
      check("t3_valid_out",     {31'b0, valid_out}, 32'd0);
      check("t3_fetch_address", fetch_address, 32'h2000);
      tick();
      check("t3_first_valid", {31'b0, valid_out}, 32'd1);
      check("t3_first_pc",    pc_out, 32'h2000);

      // Bus not ready: queued entries drain, address holds.
      tick();
      check("t4_count_before", {29'b0, count}, 32'd2);
      fetch_ready = 1'b0; stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t4_fetch_address_hold", fetch_address, 32'h2008);
         tick();
      end
      check("t4_valid_out",     {31'b0, valid_out}, 32'd0);
      check("t4_count",         {29'b0, count}, 32'd0);
      check("t4_fetch_address", fetch_address, 32'h2008);

      // Twelve words through the queue under an irregular stall pattern.
      fetch_ready = 1'b1;
      track_pops = 1'b1; last_pop = 32'h2004; n_pops = 0;
      for (int i = 0; i < 200 && n_pops < 12; i++) begin
         stall = stall_pat[i % 16];
         tick();
      end
      track_pops = 1'b0;
      check("t5_pops_done", {31'b0, (n_pops >= 12)}, 32'd1);
      check("t5_last_pop",  last_pop, 32'h2034);

      // Asynchronous reset mid-cycle with three entries queued.
      stall = 1'b1; redirect = 1'b1; redirect_vector = 32'h0000_0300;
      tick();
      redirect = 1'b0;
      repeat (3) tick();
      #1;
      check("t6_count_before", {29'b0, count}, 32'd3);
      check("t6_pc_before",    pc_out, 32'h300);
      #1;
      reset = 1'b1;
      #1;
      check("t6_valid_out",     {31'b0, valid_out}, 32'd0);
      check("t6_fetch_request", {31'b0, fetch_request}, 32'd0);
      check("t6_count",         {29'b0, count}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_fetch_address", fetch_address, RV);
      check("t6_count_after",   {29'b0, count}, 32'd0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised instruction prefetch buffer between busio's fetch port and decode. It generalises the single-register fetch stage to a DEPTH-entry FIFO, so instruction fetch keeps running while decode is stalled. A single redirect input covers branch, trap and mret; it flushes all queued entries and restarts fetch at a new vector.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 2
XLEN, 32, address and instruction width
RESET_VECTOR, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
redirect  input  1  branch taken, trap or mret; flush the queue and refetch
redirect_vector  input  XLEN  new fetch address; bits [1:0] forced to 0
fetch_request  output  1  fetch_address is valid this cycle
fetch_address  output  XLEN  address to busio
fetch_ready  input  1  busio returns fetch_data for fetch_address in this cycle
fetch_data  input  XLEN  instruction word from busio
stall  input  1  decode cannot accept head entry this cycle
pc_out  output  XLEN  pc of head entry
next_pc_out  output  XLEN  pc_out + 4, modulo 2^XLEN
instruction_out  output  XLEN  instruction of head entry
valid_out  output  1  head entry present
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- State:
  - fetch_pc register (XLEN)
  - entry array of {pc, instruction}, DEPTH entries
  - rd_ptr and wr_ptr, $clog2(DEPTH) bits each, wrapping modulo DEPTH
  - count register
- Reset (async, takes effect immediately mid-operation):
  - fetch_pc = RESET_VECTOR; rd_ptr = wr_ptr = count = 0.
  - Outputs while reset is high: fetch_request = 0, valid_out = 0, count = 0.
  - pc_out, next_pc_out and instruction_out are don't-care while valid_out = 0.
- Combinational signals each cycle:
  - valid_out = (count != 0).
  - pop = valid_out & ~stall & ~redirect.
  - fetch_request = ~redirect & ((count < DEPTH) | pop). This combinational stall-to-request path is intended.
  - fetch_address = fetch_pc.
  - push = fetch_request & fetch_ready.
- Push (on the clock edge):
  - entry[wr_ptr] <= {fetch_pc, fetch_data}; wr_ptr++; fetch_pc <= fetch_pc + 4.
- Pop (on the clock edge):
  - rd_ptr++. Head entry is consumed by decode in the same cycle.
- Count update:
  - count += push - pop.
  - Push and pop together at full: count stays DEPTH.
  - Push and pop together at empty is impossible, because pop requires count != 0.
- Redirect (highest priority):
  - Next state: rd_ptr = wr_ptr = count = 0; fetch_pc <= {redirect_vector[XLEN-1:2], 2'b00}.
  - During the redirect cycle: no push, no pop; fetch_data is ignored.
  - Head entry is not consumed; pc_out and valid_out reflect pre-flush state and decode must discard them.
- fetch_ready low: fetch_address is held, nothing is pushed, and the head may still pop.
- Latency:
  - A word accepted at edge N is visible on the outputs after edge N with valid_out = 1.
  - Empty-queue bypass is not provided. Minimum fetch-to-decode latency is 1 cycle.
- Ordering: entries leave in fetch order; no entry is duplicated or dropped except by redirect.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- fetch_pc wraps modulo 2^XLEN with no error.

Test Plan:
1. DEPTH=4, RESET_VECTOR=0x100, fetch_ready=1, stall=1 after reset release -> fetch_address 0x100, 0x104, 0x108, 0x10C accepted. Then fetch_request=0, count=4, valid_out=1, pc_out=0x100, next_pc_out=0x104.
2. From full, stall=0 with fetch_ready=1 for 6 cycles -> pc_out steps 0x100..0x114 one per cycle and count stays 4. Requests at full proceed because of pop.
3. Full queue, redirect=1 with redirect_vector=0x2003 for one cycle -> next cycle count=0, valid_out=0, fetch_address=0x2000. The next valid_out shows pc_out=0x2000; no pre-flush entry ever appears.
4. fetch_ready=0 for 3 cycles with stall=0 and 2 entries queued -> both entries drain, fetch_address stays constant, and valid_out=0 until fetch_ready returns.
5. 12 sequential words with a pseudo-random stall pattern -> output pc sequence is strictly +4 with no gaps or repeats across at least two pointer wraps, and count never exceeds 4.
6. Reset asserted asynchronously mid-cycle with count=3 -> valid_out, fetch_request and count go to 0 before the next edge. After release, fetch_address=RESET_VECTOR.
